// File: rtl/jpeg_fb_bridge_if.sv
// Pixel stream from the JPEG decoder and scan-side colour lookup from the VGA controller.
// A pixel transfers on any pclk edge where pix_valid and pix_ready are both high; the source keeps
// pix_rgb/pix_last stable while pix_valid is high and pix_ready is low, and ready never waits on valid.
interface jpeg_fb_bridge_if;
    logic        pix_valid;
    logic        pix_ready;
    logic [23:0] pix_rgb;
    logic        pix_last;
    logic [9:0]  h_addr;
    logic [9:0]  v_addr;
    logic        valid;
    logic [11:0] vga_data;

    modport master (
        output pix_valid, pix_rgb, pix_last, h_addr, v_addr, valid,
        input  pix_ready, vga_data
    );

    modport slave (
        input  pix_valid, pix_rgb, pix_last, h_addr, v_addr, valid,
        output pix_ready, vga_data
    );
endinterface

// File: rtl/jpeg_fb_bridge.sv
// Captures 8x8-block-ordered decoder pixels as RGB444 into a raster frame buffer
// and serves the colour under the VGA scan position one pclk later.
module jpeg_fb_bridge #(
    parameter int          IMG_W    = 320,
    parameter int          IMG_H    = 240,
    parameter int          ADDR_W   = 17,
    parameter logic [11:0] BG_COLOR = 12'h000
) (
    input  logic             pclk,
    input  logic             reset,
    input  logic             start,
    output logic             busy,
    output logic             frame_done,
    output logic             err,
    output logic [1:0]       fsm_state,
    jpeg_fb_bridge_if.slave  bus
);
    localparam int         DEPTH   = IMG_W * IMG_H;
    localparam logic [6:0] BX_LAST = 7'(IMG_W / 8 - 1);
    localparam logic [5:0] BY_LAST = 6'(IMG_H / 8 - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, DONE = 2'd2} state_t;
    typedef enum logic [1:0] {SEL_BLANK = 2'd0, SEL_IMG = 2'd1, SEL_BG = 2'd2} rd_sel_t;

    state_t              state;
    rd_sel_t             rd_sel;
    logic [2:0]          col;
    logic [2:0]          row;
    logic [6:0]          bx;
    logic [5:0]          by;
    logic                xfer;
    logic                last_pix;
    logic                in_img;
    logic [ADDR_W-1:0]   wr_addr;
    logic [ADDR_W-1:0]   rd_addr;
    logic [11:0]         wr_data;
    logic [11:0]         rd_word;
    logic                unused_bits;
    logic [11:0]         mem [DEPTH];

    // ready is a pure decode of the state register so it drops the instant reset asserts
    assign busy          = (state == WRITE);
    assign bus.pix_ready = busy;
    assign fsm_state     = state;
    assign xfer          = bus.pix_valid & busy;
    assign last_pix      = (by == BY_LAST) && (bx == BX_LAST) && (row == 3'd7) && (col == 3'd7);

    assign wr_addr = ADDR_W'((32'(by) * 32'd8 + 32'(row)) * 32'(IMG_W) + 32'(bx) * 32'd8 + 32'(col));
    assign wr_data = {bus.pix_rgb[23:20], bus.pix_rgb[15:12], bus.pix_rgb[7:4]};
    assign unused_bits = ^{bus.pix_rgb[19:16], bus.pix_rgb[11:8], bus.pix_rgb[3:0]};

    assign in_img  = bus.valid && (32'(bus.h_addr) < 32'(IMG_W)) && (32'(bus.v_addr) < 32'(IMG_H));
    assign rd_addr = in_img ? ADDR_W'(32'(bus.v_addr) * 32'(IMG_W) + 32'(bus.h_addr)) : '0;

    // Read-before-write on a shared address: the read sees the previous contents.
    always_ff @(posedge pclk) begin
        if (xfer) mem[wr_addr] <= wr_data;
        rd_word <= mem[rd_addr];
    end

    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            rd_sel <= SEL_BLANK;
        end else if (in_img) begin
            rd_sel <= SEL_IMG;
        end else if (bus.valid) begin
            rd_sel <= SEL_BG;
        end else begin
            rd_sel <= SEL_BLANK;
        end
    end

    always_comb begin
        bus.vga_data = 12'h000;
        case (rd_sel)
            SEL_IMG: bus.vga_data = rd_word;
            SEL_BG:  bus.vga_data = BG_COLOR;
            default: bus.vga_data = 12'h000;
        endcase
    end

    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            col        <= '0;
            row        <= '0;
            bx         <= '0;
            by         <= '0;
            frame_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= WRITE;
                        col        <= '0;
                        row        <= '0;
                        bx         <= '0;
                        by         <= '0;
                        frame_done <= 1'b0;
                        err        <= 1'b0;
                    end
                end
                WRITE: begin
                    if (xfer) begin
                        if (bus.pix_last != last_pix) err <= 1'b1;
                        col <= col + 3'd1;
                        if (col == 3'd7) begin
                            row <= row + 3'd1;
                            if (row == 3'd7) begin
                                if (bx == BX_LAST) begin
                                    bx <= '0;
                                    by <= by + 6'd1;
                                end else begin
                                    bx <= bx + 7'd1;
                                end
                            end
                        end
                        // col/row/bx wrap to zero on their own; only by needs forcing back
                        if (last_pix) begin
                            state      <= DONE;
                            frame_done <= 1'b1;
                            by         <= '0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_jpeg_fb_bridge.sv
// Directed bench for jpeg_fb_bridge on a reduced 32x24 image.
module tb_jpeg_fb_bridge;
  localparam int          W    = 32;
  localparam int          H    = 24;
  localparam int          NPIX = W * H;
  localparam logic [11:0] BG   = 12'h5A5;

  logic       pclk;
  logic       reset;
  logic       start;
  logic       busy;
  logic       frame_done;
  logic       err;
  logic [1:0] fsm_state;
  int         compared;
  int         mismatched;

  jpeg_fb_bridge_if bus();

  jpeg_fb_bridge #(.IMG_W(W), .IMG_H(H), .ADDR_W(10), .BG_COLOR(BG)) dut (
    .pclk(pclk), .reset(reset), .start(start), .busy(busy), .frame_done(frame_done),
    .err(err), .fsm_state(fsm_state), .bus(bus)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  function automatic logic [23:0] pix_data(input int n, input int salt);
    logic [7:0] r, g, b;
    if (n == 0 && salt == 0) return 24'hA5C3F0;
    r = 8'((n * 7 + salt * 53) & 255);
    g = 8'((n >> 3) + salt * 91);
    b = 8'(n ^ (salt * 108));
    return {r, g, b};
  endfunction

  // Raster position -> block-order index -> the colour the decoder sent there.
  function automatic logic [11:0] exp_color(input int x, input int y, input int salt);
    int n;
    logic [23:0] p;
    n = ((y / 8) * (W / 8) + x / 8) * 64 + (y % 8) * 8 + (x % 8);
    p = pix_data(n, salt);
    return {p[23:20], p[15:12], p[7:4]};
  endfunction

  task automatic pulse_start;
    start = 1'b1;
    @(posedge pclk); #1;
    start = 1'b0;
  endtask

  task automatic read_pixel(input int x, input int y, input logic vld, output logic [11:0] d);
    bus.h_addr = 10'(x);
    bus.v_addr = 10'(y);
    bus.valid  = vld;
    @(posedge pclk); #1;
    d = bus.vga_data;
  endtask

  task automatic send_frame(input int salt, input bit gaps, input int last_at, input int start_at,
                            output int sent, output bit done_early,
                            output logic [11:0] v_first, output logic [11:0] v_next);
    int cyc;
    bit xfer;
    bit grab_next;
    bit started;
    sent = 0; cyc = 0; done_early = 0; grab_next = 0; started = 0;
    v_first = '0; v_next = '0;
    while (sent < NPIX && cyc < 4 * NPIX) begin
      bus.pix_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      bus.pix_rgb   = pix_data(sent, salt);
      bus.pix_last  = (sent == last_at);
      if (start_at >= 0 && sent == start_at && !started) begin
        start = 1'b1;
        started = 1;
      end
      xfer = bus.pix_valid && bus.pix_ready;
      @(posedge pclk); #1;
      start = 1'b0;
      cyc++;
      if (grab_next) begin v_next = bus.vga_data; grab_next = 0; end
      if (xfer) begin
        if (sent == 0) begin v_first = bus.vga_data; grab_next = 1; end
        if (sent < NPIX - 1 && frame_done) done_early = 1;
        sent++;
      end
    end
    bus.pix_valid = 1'b0;
    bus.pix_last  = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (2) @(posedge pclk); #1;
    compared++; if (bus.pix_ready !== 1'b0) begin mismatched++; $display("FAIL por_ready: got %b want 0", bus.pix_ready); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL por_busy: got %b want 0", busy); end
    compared++; if (frame_done !== 1'b0) begin mismatched++; $display("FAIL por_done: got %b want 0", frame_done); end
    compared++; if (err !== 1'b0) begin mismatched++; $display("FAIL por_err: got %b want 0", err); end
    compared++; if (bus.vga_data !== 12'h000) begin mismatched++; $display("FAIL por_vga: got %h want 000", bus.vga_data); end
    reset = 1'b1;
    repeat (2) @(posedge pclk); #1;
    compared++; if (fsm_state !== 2'd0) begin mismatched++; $display("FAIL por_idle: got %0d want 0", fsm_state); end
    // abort a capture part-way through
    pulse_start;
    bus.h_addr = 10'd0; bus.v_addr = 10'd0; bus.valid = 1'b1; bus.pix_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.pix_rgb = pix_data(i, 9);
      @(posedge pclk); #1;
    end
    compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL mid_busy: got %b want 1", busy); end
    #3 reset = 1'b0;
    #1;
    compared++; if (bus.pix_ready !== 1'b0) begin mismatched++; $display("FAIL rst_ready: got %b want 0", bus.pix_ready); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL rst_busy: got %b want 0", busy); end
    compared++; if (frame_done !== 1'b0) begin mismatched++; $display("FAIL rst_done: got %b want 0", frame_done); end
    compared++; if (err !== 1'b0) begin mismatched++; $display("FAIL rst_err: got %b want 0", err); end
    compared++; if (bus.vga_data !== 12'h000) begin mismatched++; $display("FAIL rst_vga: got %h want 000", bus.vga_data); end
    @(posedge pclk); #1;
    reset = 1'b1;
    repeat (3) @(posedge pclk); #1;
    compared++; if (fsm_state !== 2'd0) begin mismatched++; $display("FAIL rst_idle: got %0d want 0", fsm_state); end
    compared++; if (bus.pix_ready !== 1'b0) begin mismatched++; $display("FAIL rst_idle_ready: got %b want 0", bus.pix_ready); end
    bus.pix_valid = 1'b0;
    bus.valid = 1'b0;
  endtask

  task automatic test_full_frame;
    int sent;
    bit early;
    logic [11:0] vf, vn;
    pulse_start;
    compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL ff_busy: got %b want 1", busy); end
    send_frame(0, 0, NPIX - 1, -1, sent, early, vf, vn);
    compared++; if (sent !== NPIX) begin mismatched++; $display("FAIL ff_len: got %0d want %0d", sent, NPIX); end
    compared++; if (early !== 1'b0) begin mismatched++; $display("FAIL ff_early_done: got %b want 0", early); end
    compared++; if (frame_done !== 1'b1) begin mismatched++; $display("FAIL ff_done: got %b want 1", frame_done); end
    compared++; if (err !== 1'b0) begin mismatched++; $display("FAIL ff_err: got %b want 0", err); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL ff_busy_end: got %b want 0", busy); end
    compared++; if (fsm_state !== 2'd2) begin mismatched++; $display("FAIL ff_state: got %0d want 2", fsm_state); end
  endtask

  task automatic test_readback;
    logic [11:0] d;
    read_pixel(0, 0, 1'b1, d);
    compared++; if (d !== 12'hACF) begin mismatched++; $display("FAIL rd_origin: got %h want ACF", d); end
    read_pixel(20, 11, 1'b1, d);
    compared++; if (d !== 12'h439) begin mismatched++; $display("FAIL rd_blk_1_2_3_4: got %h want 439", d); end
    read_pixel(400, 0, 1'b1, d);
    compared++; if (d !== BG) begin mismatched++; $display("FAIL rd_bg_400: got %h want %h", d, BG); end
    read_pixel(W, 0, 1'b1, d);
    compared++; if (d !== BG) begin mismatched++; $display("FAIL rd_bg_right_edge: got %h want %h", d, BG); end
    read_pixel(0, H, 1'b1, d);
    compared++; if (d !== BG) begin mismatched++; $display("FAIL rd_bg_bottom_edge: got %h want %h", d, BG); end
    read_pixel(0, 0, 1'b0, d);
    compared++; if (d !== 12'h000) begin mismatched++; $display("FAIL rd_blank: got %h want 000", d); end
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        read_pixel(x, y, 1'b1, d);
        compared++;
        if (d !== exp_color(x, y, 0)) begin mismatched++; $display("FAIL img0 (%0d,%0d): got %h want %h", x, y, d, exp_color(x, y, 0)); end
      end
    bus.valid = 1'b0;
  endtask

  task automatic test_gaps;
    int sent;
    bit early;
    logic [11:0] vf, vn, d;
    bus.h_addr = 10'd0; bus.v_addr = 10'd0; bus.valid = 1'b1;
    pulse_start;
    compared++; if (frame_done !== 1'b0) begin mismatched++; $display("FAIL gap_done_clr: got %b want 0", frame_done); end
    send_frame(1, 1, NPIX - 1, -1, sent, early, vf, vn);
    compared++; if (sent !== NPIX) begin mismatched++; $display("FAIL gap_len: got %0d want %0d", sent, NPIX); end
    compared++; if (early !== 1'b0) begin mismatched++; $display("FAIL gap_early_done: got %b want 0", early); end
    compared++; if (frame_done !== 1'b1) begin mismatched++; $display("FAIL gap_done: got %b want 1", frame_done); end
    compared++; if (err !== 1'b0) begin mismatched++; $display("FAIL gap_err: got %b want 0", err); end
    compared++; if (vf !== 12'hACF) begin mismatched++; $display("FAIL gap_rw_old: got %h want ACF", vf); end
    compared++; if (vn !== 12'h356) begin mismatched++; $display("FAIL gap_rw_new: got %h want 356", vn); end
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        read_pixel(x, y, 1'b1, d);
        compared++;
        if (d !== exp_color(x, y, 1)) begin mismatched++; $display("FAIL img1 (%0d,%0d): got %h want %h", x, y, d, exp_color(x, y, 1)); end
      end
    bus.valid = 1'b0;
  endtask

  task automatic test_early_last;
    int sent;
    bit early;
    logic [11:0] vf, vn, d;
    pulse_start;
    send_frame(2, 0, 100, -1, sent, early, vf, vn);
    compared++; if (sent !== NPIX) begin mismatched++; $display("FAIL el_len: got %0d want %0d", sent, NPIX); end
    compared++; if (early !== 1'b0) begin mismatched++; $display("FAIL el_early_done: got %b want 0", early); end
    compared++; if (frame_done !== 1'b1) begin mismatched++; $display("FAIL el_done: got %b want 1", frame_done); end
    compared++; if (err !== 1'b1) begin mismatched++; $display("FAIL el_err: got %b want 1", err); end
    repeat (4) @(posedge pclk); #1;
    compared++; if (err !== 1'b1) begin mismatched++; $display("FAIL el_err_sticky: got %b want 1", err); end
    compared++; if (frame_done !== 1'b1) begin mismatched++; $display("FAIL el_done_level: got %b want 1", frame_done); end
    read_pixel(W - 1, H - 1, 1'b1, d);
    compared++; if (d !== exp_color(W - 1, H - 1, 2)) begin mismatched++; $display("FAIL el_last_px: got %h want %h", d, exp_color(W - 1, H - 1, 2)); end
    bus.valid = 1'b0;
  endtask

  task automatic test_start_in_done;
    int sent;
    bit early;
    logic [11:0] vf, vn, d;
    pulse_start;
    compared++; if (frame_done !== 1'b0) begin mismatched++; $display("FAIL sd_done_drop: got %b want 0", frame_done); end
    compared++; if (err !== 1'b0) begin mismatched++; $display("FAIL sd_err_clr: got %b want 0", err); end
    compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL sd_busy: got %b want 1", busy); end
    send_frame(3, 0, NPIX - 1, 50, sent, early, vf, vn);
    compared++; if (sent !== NPIX) begin mismatched++; $display("FAIL sd_len: got %0d want %0d", sent, NPIX); end
    compared++; if (early !== 1'b0) begin mismatched++; $display("FAIL sd_early_done: got %b want 0", early); end
    compared++; if (frame_done !== 1'b1) begin mismatched++; $display("FAIL sd_done: got %b want 1", frame_done); end
    compared++; if (err !== 1'b0) begin mismatched++; $display("FAIL sd_err: got %b want 0", err); end
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        read_pixel(x, y, 1'b1, d);
        compared++;
        if (d !== exp_color(x, y, 3)) begin mismatched++; $display("FAIL img3 (%0d,%0d): got %h want %h", x, y, d, exp_color(x, y, 3)); end
      end
    bus.valid = 1'b0;
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    start = 1'b0;
    bus.pix_valid = 1'b0;
    bus.pix_rgb = '0;
    bus.pix_last = 1'b0;
    bus.h_addr = '0;
    bus.v_addr = '0;
    bus.valid = 1'b0;
    test_reset;
    test_full_frame;
    test_readback;
    test_gaps;
    test_early_last;
    test_start_in_done;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/jpeg_fb_bridge.md
Name: jpeg_fb_bridge

Overview:
Frame-buffer bridge between the JPEG decoder output and the VGA scan controller. Accepts decoded pixels in 8x8 block order over a valid/ready stream and stores them as RGB444 in an internal dual-port frame buffer at raster addresses. Serves the 12-bit colour the VGA controller needs for the (h_addr, v_addr, valid) it presents each pclk. The image sits at the top-left of the 640x480 display; all other active pixels show BG_COLOR.

Parameters:
IMG_W, 320, image width in pixels; multiple of 8, max 640.
IMG_H, 240, image height in pixels; multiple of 8, max 480.
ADDR_W, 17, frame-buffer address width; requires IMG_W*IMG_H <= 2^ADDR_W.
BG_COLOR, 12'h000, colour for active display pixels outside the image.

Ports:
pclk  input  1  single 25 MHz clock for both write and read sides.
reset  input  1  asynchronous, active-low reset.
start  input  1  one-cycle pulse; begins capture of a new frame.
pix_valid  input  1  decoder pixel valid.
pix_ready  output  1  bridge can accept a pixel.
pix_rgb  input  24  decoded pixel, R[23:16] G[15:8] B[7:0].
pix_last  input  1  decoder marks final pixel of the frame; qualified by transfer.
busy  output  1  high in WRITE state.
frame_done  output  1  level; high once a full frame is captured, until next start.
err  output  1  sticky; pix_last disagreed with the internal count during this frame.
h_addr  input  10  current scan column from VGA controller.
v_addr  input  10  current scan row from VGA controller.
valid  input  1  active-video flag from VGA controller.
vga_data  output  12  RGB444 colour to VGA controller, {R,G,B} nibbles.

Behaviour:
- Reset (reset=0, async): state IDLE; col, row, bx, by = 0; pix_ready, busy, frame_done, err = 0; vga_data = 12'h000. Frame-buffer contents are not cleared.
- States IDLE, WRITE, DONE. pix_ready = busy = (state==WRITE), decoded directly from the state register, so both fall immediately on reset.
- IDLE/DONE + start -> WRITE next cycle; clears all counters, frame_done and err. start while in WRITE is ignored.
- Transfer = pix_valid & pix_ready. Write address = (by*8+row)*IMG_W + bx*8 + col, truncated to ADDR_W. Write data = {pix_rgb[23:20], pix_rgb[15:12], pix_rgb[7:4]} (truncation, no rounding).
- Counter advance per transfer: col 0..7; col wraps 7->0 with row+1; at row 7, col 7: row->0, bx+1; at bx = IMG_W/8-1 with that condition: bx->0, by+1.
- Last pixel = (by==IMG_H/8-1)&(bx==IMG_W/8-1)&(row==7)&(col==7). Transfer of last pixel -> DONE next cycle, frame_done=1 that cycle; counters return to 0.
- err set on any transfer where pix_last != last-pixel condition. An early pix_last does not end the frame; only the internal count does.
- pix_valid with pix_ready=0: no write, no counter change.
- Read side, every cycle, 1-cycle latency: if valid & h_addr<IMG_W & v_addr<IMG_H, vga_data <= mem[v_addr*IMG_W+h_addr]; else if valid, vga_data <= BG_COLOR; else vga_data <= 12'h000. The top level accepts the resulting one-pixel right shift.
- Read and write to the same address in the same cycle: read returns the old contents. Reads during WRITE are allowed and show a partially updated frame.
- Reset mid-frame: capture aborts; the partial frame stays in memory; a new start is needed.

Test Plan:
- reset=0 mid-stream -> pix_ready, busy, frame_done, err, vga_data = 0 immediately; after release, state is IDLE with pix_ready=0.
- start, then 76800 pixels (IMG_W=320, IMG_H=240) with pix_valid always high and pix_last on the final pixel only -> frame_done=1 the cycle after the last transfer, err=0. Pixel at by=1, bx=2, row=3, col=4 lands at address 11*320+20 = 3540.
- Repeat with random pix_valid gaps -> identical memory image; counters hold when pix_valid=0.
- pix_last asserted on pixel 100 -> err=1 sticky, capture continues to 76800; frame_done=1 and err=1 until the next start clears both.
- After capture, with pix_rgb=24'hA5C3F0 stored at (0,0): h_addr=0, v_addr=0, valid=1 -> vga_data=12'hACF one cycle later. h_addr=400, valid=1 -> BG_COLOR. valid=0 -> 12'h000.
- start during WRITE -> ignored, counters unchanged. start in DONE -> frame_done drops next cycle and a new capture begins at address 0.
